fios_final_sub: RTL and testbench



---
 rtl/fios_pkg.sv | 13 +
 rtl/fios_word_sub.sv | 15 +
 rtl/fios_final_sub.sv | 136 +++++++++++++
 tb/tb_fios_final_sub.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fios_pkg.sv
// Shared definitions for the FIOS final-subtraction stage: word width and FSM state encoding.
package fios_pkg;

  localparam int WORD_W = 17;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    OUTPUT  = 2'd3
  } fios_fs_state_t;

endpackage

// File: rtl/fios_word_sub.sv
// One word of the borrow chain: {bout, diff} = a - b - bin, modulo 2^WORD_W.
module fios_word_sub
  import fios_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              bin,
  output logic [WORD_W-1:0] diff,
  output logic              bout
);

  // The extra top bit of the widened difference is set exactly when a < b + bin.
  assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{WORD_W{1'b0}}, bin};

endmodule

// File: rtl/fios_final_sub.sv
// Captures the multiplier's word-serial result, subtracts p on the fly and streams out
// either the raw result or result - p, whichever is the reduced value.
module fios_final_sub
  import fios_pkg::*;
#(
  parameter int s = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic [s*WORD_W-1:0]   p_i,
  input  logic                  res_valid_i,
  input  logic [WORD_W-1:0]     res_i,
  output logic                  ready_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WORD_W-1:0]     out_word_o,
  output logic                  out_last_o,
  output logic                  overrun_o
);

  localparam int IDX_W  = $clog2(s + 1);
  localparam int OIDX_W = (s > 1) ? $clog2(s) : 1;
  localparam logic [IDX_W-1:0]  IDX_CARRY  = IDX_W'(s);
  localparam logic [OIDX_W-1:0] OIDX_LAST  = OIDX_W'(s - 1);

  fios_fs_state_t     state;
  logic [IDX_W-1:0]   idx;
  logic [OIDX_W-1:0]  oidx;
  logic               borrow;
  logic               carry_nz;
  logic               final_borrow;
  logic               sel_diff;
  logic               overrun;

  logic [WORD_W-1:0]  res_buf  [s];
  logic [WORD_W-1:0]  diff_buf [s];
  logic [WORD_W-1:0]  p_words  [s];

  logic               collecting;
  logic               data_word;
  logic               buf_we;
  logic [WORD_W-1:0]  p_sel;
  logic               sub_bin;
  logic [WORD_W-1:0]  sub_diff;
  logic               sub_bout;

  for (genvar k = 0; k < s; k++) begin : g_p_words
    assign p_words[k] = p_i[k*WORD_W +: WORD_W];
  end

  // idx is 0 whenever the FSM sits in IDLE, so IDLE and COLLECT share one datapath.
  assign collecting = (state == IDLE) || (state == COLLECT);
  assign data_word  = (idx < IDX_CARRY);
  assign buf_we     = res_valid_i && collecting && data_word;
  assign p_sel      = data_word ? p_words[idx[OIDX_W-1:0]] : '0;
  assign sub_bin    = (state == COLLECT) ? borrow : 1'b0;

  fios_word_sub u_word_sub (
    .a    (res_i),
    .b    (p_sel),
    .bin  (sub_bin),
    .diff (sub_diff),
    .bout (sub_bout)
  );

  // NOTE: the word buffers carry no reset; every entry is rewritten before it is read.
  always_ff @(posedge clock_i) begin
    if (buf_we) begin
      res_buf[idx[OIDX_W-1:0]]  <= res_i;
      diff_buf[idx[OIDX_W-1:0]] <= sub_diff;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      idx          <= '0;
      oidx         <= '0;
      borrow       <= 1'b0;
      carry_nz     <= 1'b0;
      final_borrow <= 1'b0;
      sel_diff     <= 1'b0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (res_valid_i) begin
            if (data_word) begin
              borrow <= sub_bout;
              idx    <= idx + 1'b1;
              state  <= COLLECT;
            end else begin
              // Carry word: subtract only the pending borrow.
              carry_nz     <= |res_i;
              final_borrow <= sub_bout;
              borrow       <= 1'b0;
              idx          <= '0;
              state        <= DECIDE;
            end
          end
        end
        DECIDE: begin
          sel_diff <= carry_nz | ~final_borrow;
          oidx     <= '0;
          state    <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready_i) begin
            if (oidx == OIDX_LAST) begin
              oidx  <= '0;
              state <= IDLE;
            end else begin
              oidx <= oidx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      overrun <= 1'b0;
    end else if (res_valid_i && !collecting) begin
      overrun <= 1'b1;
    end
  end

  assign ready_o     = collecting;
  assign out_valid_o = (state == OUTPUT);
  assign out_last_o  = out_valid_o && (oidx == OIDX_LAST);
  assign out_word_o  = out_valid_o ? (sel_diff ? diff_buf[oidx] : res_buf[oidx]) : '0;
  assign overrun_o   = overrun;

endmodule

// File: tb/tb_fios_final_sub.sv
// Scoreboard bench for fios_final_sub (s = 2): integer reference model, random streams and handshakes.
module tb_fios_final_sub;
  import fios_pkg::*;

  localparam int S = 2;
  localparam int W = WORD_W;

  logic              clock_i;
  logic              reset_n_i;
  logic [S*W-1:0]    p_i;
  logic              res_valid_i;
  logic [W-1:0]      res_i;
  logic              ready_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [W-1:0]      out_word_o;
  logic              out_last_o;
  logic              overrun_o;

  fios_final_sub #(.s(S)) dut (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .p_i         (p_i),
    .res_valid_i (res_valid_i),
    .res_i       (res_i),
    .ready_o     (ready_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_word_o  (out_word_o),
    .out_last_o  (out_last_o),
    .overrun_o   (overrun_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [W-1:0] w;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: treat the stream as one integer and reduce it once against p.
  task automatic push_expected(input logic [S*W-1:0] words, input logic [W-1:0] carry);
    logic [63:0] r;
    logic [63:0] pv;
    logic [63:0] o;
    r  = 64'(words) + (64'(carry) << (S*W));
    pv = 64'(p_i);
    o  = (r >= pv) ? (r - pv) : r;
    for (int k = 0; k < S; k++) begin
      exp_q.push_back('{w: o[k*W +: W], last: (k == S-1)});
    end
  endtask

  // Monitor: pops and compares on every accepted output word.
  always @(negedge clock_i) begin
    exp_t e;
    if (reset_n_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(out_valid_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_word", 32'(out_word_o), 32'(e.w));
        check("out_last", 32'(out_last_o), 32'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // Entered and left at #1 after a rising edge; returns in the cycle after the carry word.
  task automatic send_stream(input logic [S*W-1:0] words, input logic [W-1:0] carry, input bit gaps);
    push_expected(words, carry);
    for (int k = 0; k <= S; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      res_valid_i = 1'b1;
      res_i       = (k < S) ? words[k*W +: W] : carry;
      tick();
      res_valid_i = 1'b0;
    end
  endtask

  task automatic drain(input bit rand_ready);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid_o) && cyc < 200) begin
      out_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      cyc++;
    end
    out_ready_i = 1'b1;
    if (cyc >= 200) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
    check({tag, "_out_last"},  32'(out_last_o),  32'd0);
    check({tag, "_out_word"},  32'(out_word_o),  32'd0);
    check({tag, "_overrun"},   32'(overrun_o),   32'd0);
    check({tag, "_ready"},     32'(ready_o),     32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  pv;
    logic [63:0]  r;
    logic [W-1:0] hold_word;
    int           cyc;
    int           mode;

    reset_n_i   = 1'b0;
    res_valid_i = 1'b0;
    res_i       = '0;
    out_ready_i = 1'b1;
    p_i         = {17'h00001, 17'h00005};
    #12;
    check_reset_outputs("reset");
    @(negedge clock_i);
    reset_n_i = 1'b1;
    tick();

    // Result >= p, with latency of the first output word.
    send_stream({17'h00001, 17'h00007}, 17'h00000, 1'b0);
    check("lat_decide_valid", 32'(out_valid_o), 32'd0);
    check("lat_decide_ready", 32'(ready_o), 32'd0);
    tick();
    check("lat_output_valid", 32'(out_valid_o), 32'd1);
    drain(1'b0);

    // Result < p, carry-word case, equality case.
    send_stream({17'h00001, 17'h00003}, 17'h00000, 1'b0);
    drain(1'b0);
    send_stream({17'h00000, 17'h00000}, 17'h00001, 1'b0);
    drain(1'b0);
    send_stream({17'h00001, 17'h00005}, 17'h00000, 1'b1);
    drain(1'b1);

    // Backpressure hold with an overrun word injected mid-hold.
    out_ready_i = 1'b0;
    send_stream({17'h00001, 17'h00007}, 17'h00000, 1'b0);
    cyc = 0;
    while (!out_valid_o && cyc < 10) begin
      tick();
      cyc++;
    end
    check("bp_valid_rise", 32'(out_valid_o), 32'd1);
    hold_word = out_word_o;
    check("bp_word0", 32'(hold_word), 32'(exp_q[0].w));
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(out_valid_o), 32'd1);
      check("bp_hold_word", 32'(out_word_o), 32'(hold_word));
      check("bp_hold_last", 32'(out_last_o), 32'd0);
      if (i == 0) check("bp_no_overrun_yet", 32'(overrun_o), 32'd0);
      if (i == 2) begin
        res_valid_i = 1'b1;
        res_i       = 17'($urandom);
      end
      tick();
      res_valid_i = 1'b0;
    end
    check("overrun_set", 32'(overrun_o), 32'd1);
    check("overrun_word", 32'(out_word_o), 32'(hold_word));
    drain(1'b0);
    check("overrun_sticky", 32'(overrun_o), 32'd1);
    check("idle_ready", 32'(ready_o), 32'd1);

    // Asynchronous reset in the middle of a collect.
    res_valid_i = 1'b1;
    res_i       = 17'h00123;
    tick();
    res_valid_i = 1'b0;
    check("mid_collect_ready", 32'(ready_o), 32'd1);
    #2 reset_n_i = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clock_i);
    reset_n_i = 1'b1;
    tick();
    send_stream({17'h00001, 17'h00007}, 17'h00000, 1'b0);
    drain(1'b0);

    // Random moduli and streams, biased towards the result ~ p boundary.
    for (int t = 0; t < 40; t++) begin
      p_i = {17'($urandom) | 17'h00001, 17'($urandom)};
      pv  = 64'(p_i);
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        r = {13'd0, 17'($urandom_range(0, 1)), 17'($urandom), 17'($urandom)};
      end else if (mode == 1) begin
        r = pv + 64'($urandom_range(0, 4)) - 64'd2;
      end else begin
        r = pv + {30'd0, 34'({$urandom, $urandom})};
      end
      send_stream(r[S*W-1:0], r[S*W +: W], 1'b1);
      drain(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
